// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the memory-mapped UART transmitter
package uart_pkg;

    localparam logic [31:0] UART_DATA_ADDR   = 32'hFFFF_0060;
    localparam logic [31:0] UART_STATUS_ADDR = 32'hFFFF_0064;
    localparam logic [31:0] UART_ACK_ADDR    = 32'hFFFF_0068;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - 8-bit synchronous FIFO with combinational head and occupancy count
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != FULL_CNT) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + ONE_PTR;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 serial transmitter with byte FIFO and drain interrupt
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        UartInterrupt,
    output logic        UartAddress,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    logic          sel_data, sel_status, sel_ack;
    logic          wr_data, wr_ack;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;
    logic          unused_data_hi;

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d, irq_set;
    logic          ovf_q, ovf_d;
    logic          baud_done;

    assign unused_data_hi = &{1'b0, data[31:8]};

    assign sel_data    = (address == UART_DATA_ADDR);
    assign sel_status  = (address == UART_STATUS_ADDR);
    assign sel_ack     = (address == UART_ACK_ADDR);
    assign UartAddress = sel_data | sel_status | sel_ack;
    assign wr_data     = MemWrite & sel_data;
    assign wr_ack      = MemWrite & sel_ack;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                                = '0;
        status_word[STAT_BUSY]                     = (state_q != IDLE);
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_EMPTY]                    = fifo_empty;
        status_word[STAT_OVF]                      = ovf_q;
        status_word[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
    end

    assign rd_data = (MemRead && UartAddress) ? (sel_status ? status_word : 32'h0) : 32'bz;

    assign baud_done = (baud_q == BAUD_LAST);

    // tx is registered, so each branch sets the line level for the state being entered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        irq_set   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        irq_set = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Setting wins over a same-cycle ACK so a drain event is never lost.
    assign irq_d = irq_set | (irq_q & ~wr_ack);
    assign ovf_d = (wr_data & fifo_full & ~fifo_pop) | (ovf_q & ~wr_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx            = tx_q;
    assign UartInterrupt = irq_q;

endmodule
